// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: FSM state
// encodings, opcode/funct constants and the datapath mux/ALU select codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13,
    S_FAULT  = 4'd15
  } state_t;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instruction[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_LUI   = 3'b101;

  // PC source select
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  // Register file destination select
  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  // Register write-back source select
  localparam logic [1:0] MR_ALUOUT = 2'b00;
  localparam logic [1:0] MR_MDR    = 2'b01;
  localparam logic [1:0] MR_PC     = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SB_B       = 2'b00;
  localparam logic [1:0] SB_FOUR    = 2'b01;
  localparam logic [1:0] SB_IMM     = 2'b10;
  localparam logic [1:0] SB_IMM_SH2 = 2'b11;

  // R-type funct values the datapath ALU implements (JR handled separately)
  function automatic logic is_rtype_alu(input logic [5:0] fn);
    case (fn)
      FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
      FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_mem_wait_timer.sv
// Counts consecutive cycles spent waiting on the shared memory and flags a
// timeout on the TIMEOUT-th such cycle. TIMEOUT = 0 disables the timeout.
//   clk       : rising-edge clock
//   reset     : synchronous, active-high
//   i_active  : FSM is in a state that waits on mem_ready
//   i_ready   : memory completed the access this cycle
//   o_timeout : this cycle is the TIMEOUT-th consecutive wait cycle
module mips_mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_active,
  input  logic i_ready,
  output logic o_timeout
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wait;

  assign w_wait = i_active && !i_ready;
  // A ready in the limit cycle is not a wait cycle, so the access completes.
  assign o_timeout = (TIMEOUT != 0) && w_wait && (r_cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (reset || !w_wait || o_timeout) r_cnt <= '0;
    else                               r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS datapath with a shared,
// variable-latency memory. Outputs are decoded from the current state; only
// the FETCH/MEMWR completion strobes are qualified by mem_ready.
//   clk, reset           : clock, synchronous active-high reset
//   opcode, funct        : fields of the instruction register
//   zero                 : ALU zero flag (used by the datapath with branch/branch_not)
//   mem_ready            : memory completed the current access
//   pc_write .. fault    : 1-bit datapath controls, retire pulse, sticky fault
//   reg_dst .. pc_src    : 2-bit mux selects; alu_op : 3-bit ALU code
//   state                : current FSM state (debug)
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch,
  output logic       branch_not,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic       imm_src,
  output logic       retire,
  output logic       fault,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_op,
  output logic [3:0] state
);

  state_t     r_state;
  logic [2:0] r_imm_alu;   // ALU op for the I-type instruction, held through IWB
  logic       r_imm_zext;  // zero-extend immediate (ANDI/ORI)
  logic       r_is_bne;
  logic       w_wait_state;
  logic       w_timeout;
  logic       w_unused_zero;

  // The branch decision itself is taken in the datapath.
  assign w_unused_zero = zero;

  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);

  mips_mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .i_active (w_wait_state),
    .i_ready  (mem_ready),
    .o_timeout(w_timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_imm_alu  <= ALU_ADD;
      r_imm_zext <= 1'b0;
      r_is_bne   <= 1'b0;
    end else if (w_timeout) begin
      r_state <= S_FAULT;
    end else begin
      case (r_state)
        S_FETCH: if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_is_bne   <= (opcode == OP_BNE);
          r_imm_zext <= (opcode == OP_ANDI) || (opcode == OP_ORI);
          case (opcode)
            OP_ANDI: r_imm_alu <= ALU_AND;
            OP_ORI:  r_imm_alu <= ALU_OR;
            OP_LUI:  r_imm_alu <= ALU_LUI;
            default: r_imm_alu <= ALU_ADD;
          endcase
          case (opcode)
            OP_RTYPE: begin
              if (funct == FN_JR)            r_state <= S_JR;
              else if (is_rtype_alu(funct))  r_state <= S_REXEC;
              else                           r_state <= S_FAULT;
            end
            OP_LW, OP_SW:                    r_state <= S_MEMADR;
            OP_BEQ, OP_BNE:                  r_state <= S_BRANCH;
            OP_ADDI, OP_ADDIU, OP_ANDI,
            OP_ORI, OP_LUI:                  r_state <= S_IEXEC;
            OP_J:                            r_state <= S_JUMP;
            OP_JAL:                          r_state <= S_JAL;
            default:                         r_state <= S_FAULT;
          endcase
        end
        S_MEMADR: r_state <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_ready) r_state <= S_MEMWB;
        S_MEMWR:  if (mem_ready) r_state <= S_FETCH;
        S_REXEC:  r_state <= S_RWB;
        S_IEXEC:  r_state <= S_IWB;
        S_MEMWB, S_RWB, S_IWB, S_BRANCH,
        S_JUMP, S_JAL, S_JR: r_state <= S_FETCH;
        S_FAULT:  r_state <= S_FAULT;
        default:  r_state <= S_FAULT;
      endcase
    end
  end

  assign state = r_state;

  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    branch_not = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    imm_src    = 1'b0;
    retire     = 1'b0;
    fault      = 1'b0;
    reg_dst    = RD_RT;
    mem_to_reg = MR_ALUOUT;
    alu_src_b  = SB_B;
    pc_src     = PC_ALU;
    alu_op     = ALU_ADD;
    // Reset silences every control so an abandoned instruction writes nothing.
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: alu_src_b = SB_IMM_SH2;
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SB_IMM;
        end
        S_MEMRD: begin
          i_or_d   = 1'b1;
          mem_read = 1'b1;
        end
        S_MEMWR: begin
          i_or_d    = 1'b1;
          mem_write = 1'b1;
          retire    = mem_ready;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = MR_MDR;
          retire     = 1'b1;
        end
        S_REXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        S_RWB: begin
          reg_write = 1'b1;
          reg_dst   = RD_RD;
          retire    = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = ALU_SUB;
          pc_src     = PC_ALUOUT;
          branch     = !r_is_bne;
          branch_not = r_is_bne;
          retire     = 1'b1;
        end
        S_IEXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SB_IMM;
          imm_src   = r_imm_zext;
          alu_op    = r_imm_alu;
        end
        S_IWB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
          imm_src   = r_imm_zext;
          alu_op    = r_imm_alu;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = PC_JUMP;
          retire   = 1'b1;
        end
        S_JAL: begin
          pc_write   = 1'b1;
          pc_src     = PC_JUMP;
          retire     = 1'b1;
          reg_write  = 1'b1;
          reg_dst    = RD_RA;
          mem_to_reg = MR_PC;
        end
        S_JR: begin
          pc_write = 1'b1;
          pc_src   = PC_RS;
          retire   = 1'b1;
        end
        S_FAULT: fault = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
